// File: rtl/wait_time_calc.sv
// wait_time_calc: sequential wait-time estimator, wtime = floor(SVC_TIME*(P+T-1)/T),
// using an MSB-first restoring divider. Define WTIME_MAX_TRACK_EN to add the wtime_max output.
module wait_time_calc #(
  parameter int PW       = 3,
  parameter int TW       = 2,
  parameter int OW       = 5,
  parameter int SVC_TIME = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [PW-1:0] pcount,
  input  logic [TW-1:0] tcount,
  output logic          busy,
  output logic          done,
  output logic [OW-1:0] wtime,
  output logic          sat
`ifdef WTIME_MAX_TRACK_EN
  ,
  output logic [OW-1:0] wtime_max
`endif
);

  localparam int NW = PW + TW + 8;
  localparam int CW = $clog2(NW + 1);

  typedef enum logic [1:0] {IDLE, LOAD, DIV, FIN} state_t;

  state_t        state;
  logic [PW-1:0] p_q;
  logic [TW-1:0] t_q;
  logic [NW-1:0] acc;        // numerator in, quotient out (shifted in at the LSB)
  logic [TW-1:0] rem;
  logic [CW-1:0] cnt;

  logic          accept;
  logic          zero_op;
  logic [TW:0]   rem_shift;
  logic          ge;
  logic [TW-1:0] rem_next;
  logic          res_sat;
  logic [OW-1:0] res_wtime;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    // The done cycle is kept separate from a fresh accept.
    accept    = start && (state == IDLE) && !done;
    zero_op   = (pcount == '0) || (tcount == '0);
    rem_shift = {rem, acc[NW-1]};
    ge        = rem_shift >= {1'b0, t_q};
    rem_next  = ge ? (rem_shift[TW-1:0] - t_q) : rem_shift[TW-1:0];
    res_sat   = |(acc >> OW);
    res_wtime = res_sat ? '1 : OW'(acc);
  end

  // NOTE: datapath registers have no reset; the FSM always loads them before use.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (accept) begin
          p_q <= pcount;
          t_q <= tcount;
          acc <= '0;
        end
      end
      LOAD: begin
        acc <= NW'(SVC_TIME) * (NW'(p_q) + NW'(t_q) - NW'(1));
        rem <= '0;
        cnt <= '0;
      end
      DIV: begin
        acc <= {acc[NW-2:0], ge};
        rem <= rem_next;
        cnt <= cnt + CW'(1);
      end
      default: ;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      wtime <= '0;
      sat   <= 1'b0;
`ifdef WTIME_MAX_TRACK_EN
      wtime_max <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            busy  <= 1'b1;
            state <= zero_op ? FIN : LOAD;
          end
        end
        LOAD: state <= DIV;
        DIV: begin
          if (cnt == CW'(NW - 1)) state <= FIN;
        end
        FIN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          wtime <= res_wtime;
          sat   <= res_sat;
`ifdef WTIME_MAX_TRACK_EN
          if (res_wtime > wtime_max) wtime_max <= res_wtime;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (done) $display("Please Wait %d Minutes To Be Served.", wtime);
  end
`endif

endmodule

// File: tb/tb_wait_time_calc.sv
// Self-checking bench for wait_time_calc: vector table, sweep, random runs and
// hand-written abort/ignore sequences; a second instance runs with OW=4.
module tb_wait_time_calc;
  localparam int PW  = 3;
  localparam int TW  = 2;
  localparam int OW  = 5;
  localparam int SVC = 3;
  localparam int NW  = PW + TW + 8;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [PW-1:0] pcount;
  logic [TW-1:0] tcount;
  logic          busy, done, sat;
  logic [OW-1:0] wtime;
  logic          busy4, done4, sat4;
  logic [3:0]    wtime4;
`ifdef WTIME_MAX_TRACK_EN
  logic [OW-1:0] wtime_max;
  logic [3:0]    wtime_max4;
  int            exp_max, exp_max4;
`endif

  wait_time_calc #(.PW(PW), .TW(TW), .OW(OW), .SVC_TIME(SVC)) dut (
    .clk(clk), .rst(rst), .start(start), .pcount(pcount), .tcount(tcount),
    .busy(busy), .done(done), .wtime(wtime), .sat(sat)
`ifdef WTIME_MAX_TRACK_EN
    , .wtime_max(wtime_max)
`endif
  );

  wait_time_calc #(.PW(PW), .TW(TW), .OW(4), .SVC_TIME(SVC)) dut4 (
    .clk(clk), .rst(rst), .start(start), .pcount(pcount), .tcount(tcount),
    .busy(busy4), .done(done4), .wtime(wtime4), .sat(sat4)
`ifdef WTIME_MAX_TRACK_EN
    , .wtime_max(wtime_max4)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic straight from the wait-time formula.
  function automatic int model_q(input int p, input int t);
    if (p == 0 || t == 0) return 0;
    return (SVC * (p + t - 1)) / t;
  endfunction

  function automatic int clamp(input int q, input int ow);
    int lim;
    lim = (1 << ow) - 1;
    return (q > lim) ? lim : q;
  endfunction

  task automatic do_calc(input int p, input int t, input int exp_w, input int exp_s,
                         input string tag);
    int lat, bcyc, q, exp_lat;
    q       = model_q(p, t);
    exp_lat = (p == 0 || t == 0) ? 1 : NW + 2;
    @(negedge clk);
    start = 1'b1; pcount = PW'(p); tcount = TW'(t);
    @(negedge clk);
    start = 1'b0; lat = 0; bcyc = 0;
    while (!done && lat < 100) begin
      if (busy) bcyc++;
      pcount = PW'($urandom);
      tcount = TW'($urandom);
      @(negedge clk);
      lat++;
    end
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " busy_cycles"}, 32'(bcyc), 32'(exp_lat));
    check({tag, " busy_at_done"}, 32'(busy), 32'd0);
    check({tag, " wtime"}, 32'(wtime), 32'(exp_w));
    check({tag, " sat"}, 32'(sat), 32'(exp_s));
    check({tag, " done_ow4"}, 32'(done4), 32'd1);
    check({tag, " wtime_ow4"}, 32'(wtime4), 32'(clamp(q, 4)));
    check({tag, " sat_ow4"}, 32'(sat4), 32'(q > 15));
`ifdef WTIME_MAX_TRACK_EN
    if (exp_w > exp_max) exp_max = exp_w;
    if (clamp(q, 4) > exp_max4) exp_max4 = clamp(q, 4);
    check({tag, " wtime_max"}, 32'(wtime_max), 32'(exp_max));
    check({tag, " wtime_max_ow4"}, 32'(wtime_max4), 32'(exp_max4));
`endif
    @(negedge clk);
    check({tag, " done_pulse"}, 32'(done), 32'd0);
    check({tag, " wtime_hold"}, 32'(wtime), 32'(exp_w));
  endtask

  typedef struct {
    int p;
    int t;
    int w;
    int s;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int ndone, w_first, p, t, q;

    vecs[0] = '{7, 1, 21, 0};
    vecs[1] = '{4, 2, 7, 0};
    vecs[2] = '{5, 3, 7, 0};
    vecs[3] = '{1, 3, 3, 0};
    vecs[4] = '{6, 2, 10, 0};
    vecs[5] = '{7, 3, 9, 0};
    vecs[6] = '{5, 0, 0, 0};
    vecs[7] = '{0, 2, 0, 0};
    vecs[8] = '{1, 1, 3, 0};

    rst = 1'b1; start = 1'b0; pcount = '0; tcount = '0;
`ifdef WTIME_MAX_TRACK_EN
    exp_max = 0; exp_max4 = 0;
`endif
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset wtime", 32'(wtime), 32'd0);
    check("reset sat", 32'(sat), 32'd0);
`ifdef WTIME_MAX_TRACK_EN
    check("reset wtime_max", 32'(wtime_max), 32'd0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 9; i++)
      do_calc(vecs[i].p, vecs[i].t, vecs[i].w, vecs[i].s, $sformatf("vec%0d", i));

    for (int ti = 1; ti <= 3; ti++)
      for (int pi = 1; pi <= 7; pi++)
        do_calc(pi, ti, clamp(model_q(pi, ti), OW), int'(model_q(pi, ti) > 31),
                $sformatf("sweep_t%0d_p%0d", ti, pi));

    for (int i = 0; i < 20; i++) begin
      p = int'($urandom_range(0, 7));
      t = int'($urandom_range(0, 3));
      q = model_q(p, t);
      do_calc(p, t, clamp(q, OW), int'(q > 31), $sformatf("rand%0d_t%0d_p%0d", i, t, p));
    end

    // Second start mid-division must be dropped, not queued.
    @(negedge clk);
    start = 1'b1; pcount = 3'd6; tcount = 2'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; pcount = 3'd1; tcount = 2'd1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; w_first = -1;
    for (int c = 0; c < 40; c++) begin
      if (done) begin
        ndone++;
        if (w_first < 0) w_first = int'(wtime);
      end
      @(negedge clk);
    end
    check("restart_ignored done_count", 32'(ndone), 32'd1);
    check("restart_ignored wtime", 32'(w_first), 32'd10);
`ifdef WTIME_MAX_TRACK_EN
    if (10 > exp_max) exp_max = 10;
    if (clamp(10, 4) > exp_max4) exp_max4 = clamp(10, 4);
`endif

    // A start raised during the done cycle itself is not accepted.
    @(negedge clk);
    start = 1'b1; pcount = 3'd7; tcount = 2'd1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 100 && !done; c++) @(negedge clk);
    check("done_cycle_start first_done", 32'(done), 32'd1);
    start = 1'b1; pcount = 3'd0; tcount = 2'd0;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int c = 0; c < 5; c++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("done_cycle_start ignored", 32'(ndone), 32'd0);
    check("done_cycle_start wtime", 32'(wtime), 32'd21);
`ifdef WTIME_MAX_TRACK_EN
    if (21 > exp_max) exp_max = 21;
    if (15 > exp_max4) exp_max4 = 15;
`endif

    // Reset in the fifth division cycle aborts with no done.
    @(negedge clk);
    start = 1'b1; pcount = 3'd7; tcount = 2'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort wtime", 32'(wtime), 32'd0);
    check("abort sat_ow4", 32'(sat4), 32'd0);
`ifdef WTIME_MAX_TRACK_EN
    exp_max = 0; exp_max4 = 0;
    check("abort wtime_max", 32'(wtime_max), 32'd0);
`endif
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("abort no_done", 32'(ndone), 32'd0);
    do_calc(7, 3, 9, 0, "after_abort");

`ifdef WTIME_MAX_TRACK_EN
    do_calc(2, 1, 6, 0, "max_a");
    do_calc(1, 1, 3, 0, "max_b");
    check("max_sequence", 32'(wtime_max), 32'd9);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
